instr_mem_loader: RTL and testbench

//  Write-side counterpart of instr_mem. It receives a program image as a byte stream over a valid/ready handshake.
//  It assembles the bytes into little-endian 32-bit words and writes them into instruction memory at word-aligned

---
 rtl/instr_mem_loader_if.sv | 24 ++
 rtl/instr_mem_loader.sv | 114 +++++++++++
 tb/tb_instr_mem_loader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Byte-stream load port and instruction-memory write port of instr_mem_loader.
// The master side feeds the program image and observes the write bus and status.
interface instr_mem_loader_if;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data, busy, done, error
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data, busy, done, error
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Loads a program image from a byte stream into instruction memory: a 4-byte little-endian
// word-count header followed by little-endian instruction words written from address 0.
module instr_mem_loader #(
  parameter int unsigned INSTR_MEM_SIZE_BYTES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  instr_mem_loader_if.slave  bus
);

  localparam int unsigned MAX_WORDS = INSTR_MEM_SIZE_BYTES / 4;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE, S_ERR} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_asm;
  logic [31:0] r_word_count;
  logic [31:0] r_word_idx;
  logic [31:0] r_addr;
  logic        r_wr_en;
  logic [31:0] r_wr_addr;
  logic [31:0] r_wr_data;

  logic        w_ready;
  logic        w_xfer;
  logic        w_last_byte;
  logic        w_last_word;
  logic [31:0] w_word_val;

  assign w_ready     = (r_state == S_HDR) || (r_state == S_DATA);
  assign w_xfer      = bus.byte_valid && w_ready;
  assign w_last_byte = (r_byte_idx == 2'd3);
  assign w_last_word = (r_word_idx == r_word_count - 32'd1);
  // Earlier bytes sit in r_asm (oldest lowest); the incoming byte completes the top lane.
  assign w_word_val  = {bus.byte_data, r_asm};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: if (bus.start) w_next = S_HDR;
      S_HDR: begin
        if (w_xfer && w_last_byte) begin
          if (w_word_val == 32'd0)                 w_next = S_DONE;
          else if (w_word_val > 32'(MAX_WORDS))    w_next = S_ERR;
          else                                     w_next = S_DATA;
        end
      end
      S_DATA: if (w_xfer && w_last_byte && w_last_word) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_idx   <= '0;
      r_asm        <= '0;
      r_word_count <= '0;
      r_word_idx   <= '0;
      r_addr       <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else begin
      r_wr_en <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            r_byte_idx   <= '0;
            r_asm        <= '0;
            r_word_count <= '0;
            r_word_idx   <= '0;
            r_addr       <= '0;
          end
        end
        S_HDR, S_DATA: begin
          if (w_xfer) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            r_asm      <= {bus.byte_data, r_asm[23:8]};
            if (w_last_byte) begin
              if (r_state == S_HDR) begin
                r_word_count <= w_word_val;
              end else begin
                r_wr_en    <= 1'b1;
                r_wr_addr  <= r_addr;
                r_wr_data  <= w_word_val;
                r_addr     <= r_addr + 32'd4;
                r_word_idx <= r_word_idx + 32'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.byte_ready = w_ready;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.busy       = w_ready || r_wr_en;
  assign bus.done       = (r_state == S_DONE);
  assign bus.error      = (r_state == S_ERR);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: a byte-count model of the load protocol is
// compared against every output on every cycle, plus literal checks of key write sequences.
module tb_instr_mem_loader;

  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned MAX_WORDS = MEM_BYTES / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_mem_loader_if bus ();

  instr_mem_loader #(.INSTR_MEM_SIZE_BYTES(MEM_BYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks the load purely by counting accepted bytes.
  bit          m_valid = 1'b0;
  bit          m_active, m_done, m_err, m_wr;
  int unsigned m_acc, m_total;
  logic [31:0] m_wr_addr, m_wr_data, m_hdr;
  logic [7:0]  m_buf [4];
  logic [63:0] wlog [$];

  always @(negedge clk) begin
    if (m_valid) begin
      check("byte_ready", 32'(bus.byte_ready), 32'(m_active));
      check("wr_en",      32'(bus.wr_en),      32'(m_wr));
      check("wr_addr",    bus.wr_addr,         m_wr_addr);
      check("wr_data",    bus.wr_data,         m_wr_data);
      check("busy",       32'(bus.busy),       32'(m_active || m_wr));
      check("done",       32'(bus.done),       32'(m_done));
      check("error",      32'(bus.error),      32'(m_err));
      if (bus.wr_en === 1'b1) wlog.push_back({bus.wr_addr, bus.wr_data});
    end
    // Predict the effect of the coming rising edge from the inputs now stable.
    if (rst) begin
      m_valid = 1'b1;
      m_active = 0; m_done = 0; m_err = 0; m_wr = 0;
      m_acc = 0; m_total = 0; m_wr_addr = '0; m_wr_data = '0;
    end else if (m_valid) begin
      m_wr = 0;
      if (m_active && bus.byte_valid) begin
        m_buf[m_acc % 4] = bus.byte_data;
        m_acc++;
        if (m_acc == 4) begin
          m_hdr = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
          if (m_hdr == 0)              begin m_active = 0; m_done = 1; end
          else if (m_hdr > MAX_WORDS)  begin m_active = 0; m_err  = 1; end
          else                         m_total = 4 + 4 * m_hdr;
        end else if (m_acc % 4 == 0) begin
          m_wr      = 1;
          m_wr_addr = m_acc - 8;
          m_wr_data = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
          if (m_acc == m_total) begin m_active = 0; m_done = 1; end
        end
      end else if (bus.start && !m_active) begin
        m_active = 1; m_done = 0; m_err = 0; m_acc = 0; m_total = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) tick();
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = bus.byte_ready;
      tick();
    end
    bus.byte_valid = 1'b0;
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gmin, input int gmax);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], int'($urandom_range(gmax, gmin)));
  endtask

  task automatic check_write(input int idx, input logic [31:0] addr, input logic [31:0] data);
    if (idx < wlog.size()) begin
      check($sformatf("log%0d_addr", idx), wlog[idx][63:32], addr);
      check($sformatf("log%0d_data", idx), wlog[idx][31:0],  data);
    end else begin
      check($sformatf("log%0d_missing", idx), 32'(wlog.size()), 32'(idx + 1));
    end
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    check({tag, "_wr_en"}, 32'(bus.wr_en),      32'd0);
    check({tag, "_addr"},  bus.wr_addr,         32'd0);
    check({tag, "_data"},  bus.wr_data,         32'd0);
    check({tag, "_busy"},  32'(bus.busy),       32'd0);
    check({tag, "_done"},  32'(bus.done),       32'd0);
    check({tag, "_error"}, 32'(bus.error),      32'd0);
    tick();
  endtask

  initial begin
    logic [31:0] img [3];
    int n;
    img[0] = 32'h00100513; img[1] = 32'h00200593; img[2] = 32'h00a58633;
    bus.start = 1'b0; bus.byte_valid = 1'b0; bus.byte_data = '0;
    tick(); tick();
    rst = 1'b0;
    check_all_zero("reset");

    // Three-word program, no gaps.
    wlog.delete();
    pulse_start();
    send_word(32'd3, 0, 0);
    for (int i = 0; i < 3; i++) send_word(img[i], 0, 0);
    tick(); tick();
    check("t1_count", 32'(wlog.size()), 32'd3);
    for (int i = 0; i < 3; i++) check_write(i, 32'(4 * i), img[i]);
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_busy", 32'(bus.busy), 32'd0);

    // Same program with 1-3 idle cycles between bytes.
    wlog.delete();
    pulse_start();
    send_word(32'd3, 1, 3);
    for (int i = 0; i < 3; i++) send_word(img[i], 1, 3);
    repeat (4) tick();
    check("t2_count", 32'(wlog.size()), 32'd3);
    for (int i = 0; i < 3; i++) check_write(i, 32'(4 * i), img[i]);
    check("t2_done", 32'(bus.done), 32'd1);

    // Empty program.
    wlog.delete();
    pulse_start();
    send_word(32'd0, 0, 0);
    @(negedge clk);
    check("t3_done",  32'(bus.done),       32'd1);
    check("t3_ready", 32'(bus.byte_ready), 32'd0);
    tick(); tick();
    check("t3_count", 32'(wlog.size()), 32'd0);

    // Oversized header, then a full-memory image.
    wlog.delete();
    pulse_start();
    send_word(32'd257, 0, 0);
    tick();
    check("t4_error", 32'(bus.error), 32'd1);
    check("t4_nowr",  32'(wlog.size()), 32'd0);
    pulse_start();
    check("t4_error_clr", 32'(bus.error), 32'd0);
    send_word(32'd256, 0, 0);
    for (int i = 0; i < 256; i++) send_word($urandom, 0, 0);
    tick(); tick();
    check("t4_count", 32'(wlog.size()), 32'd256);
    if (wlog.size() == 256) check("t4_last_addr", wlog[255][63:32], 32'h3FC);

    // Reset in the middle of a word, then a one-word image.
    wlog.delete();
    pulse_start();
    send_word(32'd2, 0, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("t5_rst");
    pulse_start();
    send_word(32'd1, 0, 0);
    send_word(32'hdeadbeef, 0, 0);
    tick(); tick();
    check("t5_count", 32'(wlog.size()), 32'd1);
    check_write(0, 32'h0, 32'hdeadbeef);

    // start mid-DATA is ignored; start in DONE reloads from address 0.
    wlog.delete();
    pulse_start();
    send_word(32'd2, 0, 0);
    send_word(32'hcafef00d, 0, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    tick(); tick();
    check("t6_count", 32'(wlog.size()), 32'd2);
    check_write(0, 32'h0, 32'hcafef00d);
    check_write(1, 32'h4, 32'h04030201);
    pulse_start();
    check("t6_done_clr", 32'(bus.done), 32'd0);
    check("t6_ready",    32'(bus.byte_ready), 32'd1);
    wlog.delete();
    send_word(32'd1, 0, 0);
    send_word(32'h12345678, 0, 0);
    tick(); tick();
    check_write(0, 32'h0, 32'h12345678);

    // Random loads followed by surplus stream bytes that must be refused.
    for (int k = 0; k < 6; k++) begin
      wlog.delete();
      n = int'($urandom_range(8, 1));
      pulse_start();
      send_word(32'(n), 0, 2);
      for (int i = 0; i < n; i++) send_word($urandom, 0, 2);
      bus.byte_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
        bus.byte_data = 8'($urandom);
        tick();
      end
      bus.byte_valid = 1'b0;
      tick();
      check("rand_count", 32'(wlog.size()), 32'(n));
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
